// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the game level countdown timer.
package game_timer_pkg;

  localparam int SECS_W = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd2_t;

  // Repeated subtraction keeps the conversion free of dividers; inputs never exceed 99.
  function automatic bcd2_t to_bcd2(input logic [SECS_W-1:0] value);
    bcd2_t res;
    logic [SECS_W-1:0] rem;
    res.tens = '0;
    rem = value;
    for (int i = 0; i < 9; i++) begin
      if (rem >= SECS_W'(10)) begin
        rem = rem - SECS_W'(10);
        res.tens = res.tens + 4'd1;
      end
    end
    res.ones = bcd_digit_t'(rem);
    return res;
  endfunction

endpackage

// File: rtl/game_timer_ctrl_sec_prescaler.sv
// One-second prescaler: counts enabled cycles and flags the last cycle of each game second.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 31_500_000,
  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic          terminal,
  output logic [CW-1:0] count
);

  assign terminal = (count == CW'(TICKS_PER_SEC - 1));

  // A disabled counter simply holds, which is what preserves a partial second across a pause.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Level countdown controller: sequences the second prescaler and drives HUD/time-up outputs.
// Optional bonus-time input enabled by defining GAME_TIMER_BONUS_EN.
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC   = 31_500_000,
  parameter int MAX_SECONDS     = 99,
  parameter int DEFAULT_SECONDS = 60,
  parameter int WARN_SECONDS    = 10
) (
  input  logic              clk,
  input  logic              reset,
`ifdef GAME_TIMER_BONUS_EN
  input  logic              add_valid,
  input  logic [3:0]        add_seconds,
`endif
  input  logic              start,
  input  logic [SECS_W-1:0] load_seconds,
  input  logic              pause_req,
  input  logic              resume_req,
  output logic [SECS_W-1:0] secs_left,
  output bcd_digit_t        secs_tens,
  output bcd_digit_t        secs_ones,
  output logic              running,
  output logic              paused,
  output logic              sec_tick,
  output logic              warning,
  output logic              time_up,
  output logic              expired
);

  localparam logic [SECS_W:0]   MAX_WIDE = (SECS_W + 1)'(MAX_SECONDS);
  localparam logic [SECS_W-1:0] MAX_SECS = SECS_W'(MAX_SECONDS);

  timer_state_t      state, state_next;
  logic              terminal;
  logic              tick_now;
  logic              expire_now;
  logic [SECS_W-1:0] load_val;
  logic [SECS_W-1:0] secs_next;
  logic [SECS_W:0]   secs_sum;
  bcd2_t             bcd_next;
  logic              running_next, paused_next, warning_next, expired_next;

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clear   (start),
    .enable  ((state == RUNNING) && !pause_req && !start),
    .terminal(terminal),
    .count   ()
  );

  // A pending pause or restart always beats the terminal count.
  assign tick_now = (state == RUNNING) && terminal && !pause_req && !start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      secs_left <= '0;
      secs_tens <= '0;
      secs_ones <= '0;
      running   <= 1'b0;
      paused    <= 1'b0;
      sec_tick  <= 1'b0;
      warning   <= 1'b0;
      time_up   <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_next;
      secs_left <= secs_next;
      secs_tens <= bcd_next.tens;
      secs_ones <= bcd_next.ones;
      running   <= running_next;
      paused    <= paused_next;
      sec_tick  <= tick_now;
      warning   <= warning_next;
      time_up   <= expire_now;
      expired   <= expired_next;
    end
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUNNING;
    end else begin
      unique case (state)
        RUNNING: begin
          if (pause_req) state_next = PAUSED;
          else if (expire_now) state_next = EXPIRED;
        end
        PAUSED:  if (resume_req) state_next = RUNNING;
        default: state_next = state;
      endcase
    end
  end

  // Bonus time and the decrement combine in one sum so a last-second pickup can rescue the level.
  always_comb begin
    load_val = (load_seconds == '0) ? SECS_W'(DEFAULT_SECONDS) : load_seconds;
    if (load_val > MAX_SECS) load_val = MAX_SECS;

    secs_sum = {1'b0, secs_left};
`ifdef GAME_TIMER_BONUS_EN
    if (add_valid && !start && ((state == RUNNING) || (state == PAUSED)))
      secs_sum = secs_sum + {{(SECS_W - 3){1'b0}}, add_seconds};
`endif
    if (tick_now) secs_sum = secs_sum - (SECS_W + 1)'(1);
    if (secs_sum > MAX_WIDE) secs_sum = MAX_WIDE;

    secs_next  = start ? load_val : secs_sum[SECS_W-1:0];
    expire_now = tick_now && (secs_next == '0);

    bcd_next     = to_bcd2(secs_next);
    running_next = (state_next == RUNNING);
    paused_next  = (state_next == PAUSED);
    expired_next = (state_next == EXPIRED);
    warning_next = (running_next || paused_next) && (secs_next != '0) &&
                   (secs_next <= SECS_W'(WARN_SECONDS));
  end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench for game_timer_ctrl with a cycle-level reference model.
// Exercises the bonus-time ports as well when GAME_TIMER_BONUS_EN is defined.
module tb_game_timer_ctrl;

  localparam int TPS = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  typedef struct packed {
    logic [6:0] secs;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       paused;
    logic       sec_tick;
    logic       warning;
    logic       time_up;
    logic       expired;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] load_seconds = '0;
  logic       pause_req = 1'b0;
  logic       resume_req = 1'b0;
  logic       add_valid = 1'b0;
  logic [3:0] add_seconds = '0;

  logic [6:0] secs_left;
  logic [3:0] secs_tens, secs_ones;
  logic       running, paused, sec_tick, warning, time_up, expired;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_mode = M_IDLE;
  int m_secs = 0;
  int m_phase = 0;
  bit m_tick = 0;
  bit m_tup = 0;

  always #5 clk = ~clk;

  game_timer_ctrl #(
    .TICKS_PER_SEC(TPS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef GAME_TIMER_BONUS_EN
    .add_valid   (add_valid),
    .add_seconds (add_seconds),
`endif
    .start       (start),
    .load_seconds(load_seconds),
    .pause_req   (pause_req),
    .resume_req  (resume_req),
    .secs_left   (secs_left),
    .secs_tens   (secs_tens),
    .secs_ones   (secs_ones),
    .running     (running),
    .paused      (paused),
    .sec_tick    (sec_tick),
    .warning     (warning),
    .time_up     (time_up),
    .expired     (expired)
  );

  // Reference: game seconds elapse as whole groups of TPS running cycles.
  task automatic model_step(input bit r, input bit s, input int ld, input bit p,
                            input bit rs, input bit av, input int as);
    int prev_mode;
    int next_secs;
    bit ticked;
    prev_mode = m_mode;
    ticked = 0;
    m_tick = 0;
    m_tup = 0;
    if (r) begin
      m_mode = M_IDLE;
      m_secs = 0;
      m_phase = 0;
    end else if (s) begin
      m_secs = (ld == 0) ? 60 : ld;
      if (m_secs > 99) m_secs = 99;
      m_phase = 0;
      m_mode = M_RUN;
    end else begin
      if (m_mode == M_RUN && p) m_mode = M_PAUSE;
      else if (m_mode == M_PAUSE && rs) m_mode = M_RUN;
      else if (m_mode == M_RUN) begin
        if (m_phase == TPS - 1) begin
          m_phase = 0;
          ticked = 1;
        end else begin
          m_phase++;
        end
      end
      next_secs = m_secs - (ticked ? 1 : 0);
      if (av && (prev_mode == M_RUN || prev_mode == M_PAUSE)) next_secs += as;
      if (next_secs > 99) next_secs = 99;
      m_secs = next_secs;
      m_tick = ticked;
      if (ticked && m_secs == 0) begin
        m_tup = 1;
        m_mode = M_EXP;
      end
    end
  endtask

  function automatic obs_t model_outputs();
    obs_t o;
    o.secs     = 7'(m_secs);
    o.tens     = 4'(m_secs / 10);
    o.ones     = 4'(m_secs % 10);
    o.running  = (m_mode == M_RUN);
    o.paused   = (m_mode == M_PAUSE);
    o.sec_tick = m_tick;
    o.warning  = (m_mode == M_RUN || m_mode == M_PAUSE) && m_secs >= 1 && m_secs <= 10;
    o.time_up  = m_tup;
    o.expired  = (m_mode == M_EXP);
    return o;
  endfunction

  // Drives one cycle of inputs at the falling edge and queues the expected post-edge outputs.
  task automatic apply_stimulus(input bit r, input bit s, input int ld, input bit p,
                                input bit rs, input bit av, input int as);
    bit av_eff;
    @(negedge clk);
`ifdef GAME_TIMER_BONUS_EN
    av_eff = av;
`else
    av_eff = 0;
`endif
    reset        = r;
    start        = s;
    load_seconds = 7'(ld);
    pause_req    = p;
    resume_req   = rs;
    add_valid    = av_eff;
    add_seconds  = 4'(as);
    model_step(r, s, ld, p, rs, av_eff, as);
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_output(input obs_t e);
    obs_t a;
    a = {secs_left, secs_tens, secs_ones, running, paused, sec_tick, warning, time_up, expired};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL outputs @%0t: got secs=%0d bcd=%0d%0d run=%b pau=%b tick=%b warn=%b up=%b exp=%b, want secs=%0d bcd=%0d%0d run=%b pau=%b tick=%b warn=%b up=%b exp=%b",
               $time, a.secs, a.tens, a.ones, a.running, a.paused, a.sec_tick, a.warning,
               a.time_up, a.expired, e.secs, e.tens, e.ones, e.running, e.paused,
               e.sec_tick, e.warning, e.time_up, e.expired);
    end
  endtask

  // Monitor: every clock presents a new registered output word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    int ld;
    $display("[TB] starting game_timer_ctrl bench");
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0);

    apply_stimulus(0, 1, 3, 0, 0, 0, 0);
    idle(16);

    apply_stimulus(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    apply_stimulus(0, 1, 120, 0, 0, 0, 0);
    idle(2);

    apply_stimulus(0, 1, 5, 0, 0, 0, 0);
    idle(1);
    apply_stimulus(0, 0, 0, 1, 0, 0, 0);
    idle(10);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0);
    idle(6);

    apply_stimulus(0, 1, 5, 0, 0, 0, 0);
    idle(3);
    apply_stimulus(0, 0, 0, 1, 0, 0, 0);
    idle(3);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0);
    idle(2);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0);
    idle(2);

    apply_stimulus(0, 1, 8, 0, 0, 0, 0);
    idle(5);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    apply_stimulus(0, 1, 9, 0, 0, 0, 0);
    idle(6);

    apply_stimulus(0, 1, 1, 0, 0, 0, 0);
    idle(3);
    apply_stimulus(0, 0, 0, 0, 0, 1, 5);
    idle(2);
    apply_stimulus(0, 1, 97, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 5);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      ld = ($urandom_range(0, 9) < 5) ? $urandom_range(1, 4) :
           ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 127);
      if (r == 0)      apply_stimulus(1, 0, 0, 0, 0, 0, 0);
      else if (r < 6)  apply_stimulus(0, 1, ld, 0, 0, 0, 0);
      else if (r < 18) apply_stimulus(0, 0, 0, 1, 0, 0, 0);
      else if (r < 32) apply_stimulus(0, 0, 0, 0, 1, 0, 0);
      else if (r < 44) apply_stimulus(0, 0, 0, 0, 0, 1, $urandom_range(0, 15));
      else             apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    end

    idle(1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
